matrix_mem_mp: RTL and testbench
================================

Name: matrix_mem_mp

Overview:
Parametrised multi-port matrix store for the execution engine, successor to the fixed six-entry, 256-bit matrix data memory. It holds DEPTH square matrices of DIM x DIM elements, each ELEM_W bits wide. It provides:
- two registered read ports, each with optional transpose-on-read;
- one write port with a per-element write mask;
- same-cycle write-to-read forwarding;
- a sequenced bulk-clear engine with a busy flag.

Parameters:
ELEM_W, 16, bits per matrix element
DIM, 4, matrix dimension (DIM x DIM elements)
DEPTH, 8, number of matrix entries
MAT_W, ELEM_W*DIM*DIM (256), derived: packed matrix width
AW, $clog2(DEPTH) (3), derived: address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
clear_req  in  1  pulse: start bulk clear of all entries
busy  out  1  high while clear sequence runs
wr_en  in  1  write strobe
wr_addr  in  AW  write entry index
wr_mask  in  DIM*DIM  element enable; bit r*DIM+c selects element [r][c]
wr_data  in  MAT_W  packed write matrix
wr_err  out  1  one-cycle pulse: write address >= DEPTH
rdN_en  in  1  read strobe, N=1,2
rdN_addr  in  AW  read entry index
rdN_transpose  in  1  return transpose of the entry
rdN_data  out  MAT_W  registered read data
rdN_valid  out  1  one-cycle pulse: rdN_data updated
rdN_err  out  1  one-cycle pulse with rdN_valid: address >= DEPTH

Behaviour:
- Packing: element [r][c] occupies bits (r*DIM+c)*ELEM_W +: ELEM_W. Row 0, column 0 is in the LSBs.
- Reset asserted (reset=0), asynchronously:
  - all outputs go to 0, except busy=1;
  - the FSM enters CLEAR with clear_idx=0.
  - Array contents are not touched asynchronously.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each rising edge writes 0 to entry clear_idx, then increments clear_idx.
  - After entry DEPTH-1 is written, the FSM enters IDLE and busy drops on that same edge.
  - busy is therefore high for exactly DEPTH cycles after reset release, or after clear_req is accepted.
  - In CLEAR, wr_en, rdN_en and clear_req are ignored. No valid, err or ack pulses are produced, and rdN_data holds its value.
- IDLE:
  - clear_req=1 moves the FSM to CLEAR with clear_idx=0 and busy=1 on the next edge.
  - A write or read presented in the same cycle as clear_req is dropped.
- Reset asserted mid-clear restarts the sequence from entry 0.
- Write, in IDLE with wr_en=1 and wr_addr<DEPTH:
  - At the edge, elements with wr_mask=1 take wr_data; the others keep their stored value.
  - wr_mask=0 performs no change and raises no error.
- Write with wr_addr>=DEPTH: ignored; wr_err=1 for one cycle.
- Read latency is 1. rdN_en sampled at edge k sets rdN_data and rdN_valid=1 after edge k; rdN_valid returns to 0 the following cycle unless rdN_en is still high.
- rdN_data holds its last value when rdN_en=0. It is never driven to z.
- Forwarding: if wr_en=1 with a valid address and rdN_addr==wr_addr in the same cycle, rdN returns the merged post-write matrix.
- Transpose: when rdN_transpose=1, output element [r][c] equals the stored/forwarded element [c][r]. Transpose is applied after the forwarding merge.
- Read with rdN_addr>=DEPTH: rdN_data=0, rdN_valid=1, rdN_err=1 for one cycle.
- Both read ports are fully independent. Identical addresses are legal on both ports and on the write port simultaneously.

Test Plan:
1. Release reset at t0 -> busy=1 for 8 cycles, then 0. Read of each of entries 0..7 returns 256'h0 with rd1_valid one cycle after rd1_en.
2. Write entry 2 with all-ones mask and element[r][c]=r*4+c, then the next cycle read rd1 (transpose=0) and rd2 (transpose=1) at address 2 -> rd1 element[1][3]=7; rd2 element[1][3]=13.
3. Write entry 2 with mask=16'h0001 and data element[0][0]=16'hBEEF, while rd1 reads address 2 in the same cycle -> rd1_data element[0][0]=16'hBEEF, other elements unchanged (element[3][3]=15).
4. wr_addr=3'd7 with DEPTH=6, and rd2_addr=3'd6 -> wr_err pulse, no array change; rd2_data=0, rd2_valid=1, rd2_err=1.
5. Pulse clear_req alongside wr_en to entry 2 -> write dropped; busy=1 for 8 cycles; reads issued during busy produce no rd1_valid; entry 2 then reads 0.
6. Assert reset at clear cycle 4 -> outputs go to 0 immediately; after release, busy=1 for a full 8 cycles.

Source files
------------

// File: rtl/matrix_mem_mp.sv
// matrix_mem_mp: multi-port store of DEPTH square DIM x DIM matrices.
// Two registered read ports with optional transpose, one masked write port,
// write-to-read forwarding, and a sequenced bulk clear that runs out of reset
// and on request. Element [r][c] sits at bits (r*DIM+c)*ELEM_W +: ELEM_W.
module matrix_mem_mp #(
  parameter int ELEM_W = 16,
  parameter int DIM    = 4,
  parameter int DEPTH  = 8,
  parameter int MAT_W  = ELEM_W * DIM * DIM,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DIM*DIM-1:0]   wr_mask,
  input  logic [MAT_W-1:0]     wr_data,
  output logic                 wr_err,
  input  logic                 rd1_en,
  input  logic [AW-1:0]        rd1_addr,
  input  logic                 rd1_transpose,
  output logic [MAT_W-1:0]     rd1_data,
  output logic                 rd1_valid,
  output logic                 rd1_err,
  input  logic                 rd2_en,
  input  logic [AW-1:0]        rd2_addr,
  input  logic                 rd2_transpose,
  output logic [MAT_W-1:0]     rd2_data,
  output logic                 rd2_valid,
  output logic                 rd2_err
);

  localparam int            NELEM    = DIM * DIM;
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clear_idx_q, clear_idx_d;
  logic              clear_we, wr_fire, wr_bad, rd1_fire, rd2_fire;
  logic              wr_ok, rd1_ok, rd2_ok;
  logic [MAT_W-1:0]  wr_old, wr_merged, rd1_raw, rd2_raw, rd1_next, rd2_next;

  logic [MAT_W-1:0]  mem [DEPTH];

  // Per-element select: masked elements take new data, others keep old.
  function automatic logic [MAT_W-1:0] merge(input logic [MAT_W-1:0] old_m,
                                             input logic [MAT_W-1:0] new_m,
                                             input logic [NELEM-1:0] mask);
    logic [MAT_W-1:0] m;
    m = old_m;
    for (int i = 0; i < NELEM; i++)
      if (mask[i]) m[i*ELEM_W +: ELEM_W] = new_m[i*ELEM_W +: ELEM_W];
    return m;
  endfunction

  // Output element [r][c] takes input element [c][r].
  function automatic logic [MAT_W-1:0] transpose(input logic [MAT_W-1:0] m);
    logic [MAT_W-1:0] t;
    t = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        t[(r*DIM+c)*ELEM_W +: ELEM_W] = m[(c*DIM+r)*ELEM_W +: ELEM_W];
    return t;
  endfunction

  assign busy = (state_q == CLEAR);

  // FSM state register; reset restarts the clear sequence from entry 0.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!reset) begin
      state_q     <= CLEAR;
      clear_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  // Next-state and per-cycle command qualification.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    clear_we    = 1'b0;
    wr_fire     = 1'b0;
    wr_bad      = 1'b0;
    rd1_fire    = 1'b0;
    rd2_fire    = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_we = 1'b1;
        if (clear_idx_q == LAST_IDX) state_d = IDLE;
        else                         clear_idx_d = clear_idx_q + 1'b1;
      end
      IDLE: begin
        if (clear_req) begin
          // Commands arriving with the clear request are dropped.
          state_d     = CLEAR;
          clear_idx_d = '0;
        end else begin
          wr_fire  = wr_en & wr_ok;
          wr_bad   = wr_en & ~wr_ok;
          rd1_fire = rd1_en;
          rd2_fire = rd2_en;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Address checks, write merge, forwarding and transpose for both read ports.
  always_comb begin
    wr_ok     = {1'b0, wr_addr}  < DEPTH_W;
    rd1_ok    = {1'b0, rd1_addr} < DEPTH_W;
    rd2_ok    = {1'b0, rd2_addr} < DEPTH_W;
    wr_old    = wr_ok ? mem[wr_addr] : '0;
    wr_merged = merge(wr_old, wr_data, wr_mask);
    rd1_raw   = '0;
    rd2_raw   = '0;
    if (rd1_ok) rd1_raw = (wr_fire && rd1_addr == wr_addr) ? wr_merged : mem[rd1_addr];
    if (rd2_ok) rd2_raw = (wr_fire && rd2_addr == wr_addr) ? wr_merged : mem[rd2_addr];
    rd1_next  = rd1_transpose ? transpose(rd1_raw) : rd1_raw;
    rd2_next  = rd2_transpose ? transpose(rd2_raw) : rd2_raw;
  end

  // Storage array: cleared entry by entry by the FSM, written by the write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the clear sequence zeroes it one entry per cycle.
    if (clear_we)     mem[clear_idx_q] <= '0;
    else if (wr_fire) mem[wr_addr]     <= wr_merged;
  end

  // Registered read results and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_err    <= 1'b0;
      rd1_data  <= '0;
      rd1_valid <= 1'b0;
      rd1_err   <= 1'b0;
      rd2_data  <= '0;
      rd2_valid <= 1'b0;
      rd2_err   <= 1'b0;
    end else begin
      wr_err    <= wr_bad;
      rd1_valid <= rd1_fire;
      rd1_err   <= rd1_fire & ~rd1_ok;
      rd2_valid <= rd2_fire;
      rd2_err   <= rd2_fire & ~rd2_ok;
      if (rd1_fire) rd1_data <= rd1_next;
      if (rd2_fire) rd2_data <= rd2_next;
    end
  end

endmodule

// File: tb/tb_matrix_mem_mp.sv
// Directed bench for matrix_mem_mp: an eight-entry instance for the main
// sequence and a six-entry instance for out-of-range addressing.
module tb_matrix_mem_mp;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Eight-entry instance
  logic         clear_req, busy, wr_en, wr_err;
  logic [2:0]   wr_addr, rd1_addr, rd2_addr;
  logic [15:0]  wr_mask;
  logic [255:0] wr_data, rd1_data, rd2_data;
  logic         rd1_en, rd1_transpose, rd1_valid, rd1_err;
  logic         rd2_en, rd2_transpose, rd2_valid, rd2_err;

  // Six-entry instance
  logic         s_clear_req, s_busy, s_wr_en, s_wr_err;
  logic [2:0]   s_wr_addr, s_rd1_addr, s_rd2_addr;
  logic [15:0]  s_wr_mask;
  logic [255:0] s_wr_data, s_rd1_data, s_rd2_data;
  logic         s_rd1_en, s_rd1_transpose, s_rd1_valid, s_rd1_err;
  logic         s_rd2_en, s_rd2_transpose, s_rd2_valid, s_rd2_err;

  matrix_mem_mp u_dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data), .wr_err(wr_err),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_transpose(rd1_transpose),
    .rd1_data(rd1_data), .rd1_valid(rd1_valid), .rd1_err(rd1_err),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_transpose(rd2_transpose),
    .rd2_data(rd2_data), .rd2_valid(rd2_valid), .rd2_err(rd2_err)
  );

  matrix_mem_mp #(.DEPTH(6)) u_dut6 (
    .clk(clk), .reset(reset), .clear_req(s_clear_req), .busy(s_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_mask(s_wr_mask), .wr_data(s_wr_data), .wr_err(s_wr_err),
    .rd1_en(s_rd1_en), .rd1_addr(s_rd1_addr), .rd1_transpose(s_rd1_transpose),
    .rd1_data(s_rd1_data), .rd1_valid(s_rd1_valid), .rd1_err(s_rd1_err),
    .rd2_en(s_rd2_en), .rd2_addr(s_rd2_addr), .rd2_transpose(s_rd2_transpose),
    .rd2_data(s_rd2_data), .rd2_valid(s_rd2_valid), .rd2_err(s_rd2_err)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [255:0] pat, pat_t, pat_b, ones, hold;
  int n;
  logic saw_valid;

  initial begin
    clear_req = 0; wr_en = 0; wr_addr = 0; wr_mask = 0; wr_data = '0;
    rd1_en = 0; rd1_addr = 0; rd1_transpose = 0; rd2_en = 0; rd2_addr = 0; rd2_transpose = 0;
    s_clear_req = 0; s_wr_en = 0; s_wr_addr = 0; s_wr_mask = 0; s_wr_data = '0;
    s_rd1_en = 0; s_rd1_addr = 0; s_rd1_transpose = 0; s_rd2_en = 0; s_rd2_addr = 0; s_rd2_transpose = 0;

    // Hand-built matrices: pat[r][c] = r*4+c, pat_t[r][c] = c*4+r.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        pat[(r*4+c)*16 +: 16]   = 16'(r*4 + c);
        pat_t[(r*4+c)*16 +: 16] = 16'(c*4 + r);
      end
    ones = '1;
    pat_b = pat;
    pat_b[15:0] = 16'hBEEF;

    // Reset state
    #2;
    check("reset_busy", busy, 1);
    check("reset_rd1_data", rd1_data, 0);
    check("reset_rd1_valid", rd1_valid, 0);
    check("reset_wr_err", wr_err, 0);
    check("reset_s_busy", s_busy, 1);

    // 1. Release reset: busy for exactly 8 cycles
    step();
    reset = 1;
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    check("init_busy_cycles", n, 8);
    check("init_s_busy_done", s_busy, 0);

    for (int a = 0; a < 8; a++) begin
      rd1_en = 1; rd1_addr = 3'(a);
      step();
      check($sformatf("init_rd_valid_%0d", a), rd1_valid, 1);
      check($sformatf("init_rd_data_%0d", a), rd1_data, 0);
    end
    rd1_en = 0;
    step();
    check("init_valid_drop", rd1_valid, 0);

    // 2. Full write then plain and transposed reads
    wr_en = 1; wr_addr = 2; wr_mask = 16'hFFFF; wr_data = pat;
    step();
    wr_en = 0;
    rd1_en = 1; rd1_addr = 2; rd1_transpose = 0;
    rd2_en = 1; rd2_addr = 2; rd2_transpose = 1;
    step();
    check("t2_rd1_data", rd1_data, pat);
    check("t2_rd1_e13", rd1_data[7*16 +: 16], 7);
    check("t2_rd2_data", rd2_data, pat_t);
    check("t2_rd2_e13", rd2_data[7*16 +: 16], 13);
    check("t2_rd2_valid", rd2_valid, 1);
    check("t2_rd1_err", rd1_err, 0);

    // Zero mask: no change, no error, forwarded read sees stored value
    wr_en = 1; wr_addr = 2; wr_mask = 16'h0000; wr_data = ones;
    rd1_en = 0; rd2_en = 1; rd2_addr = 2; rd2_transpose = 0;
    step();
    check("mask0_wr_err", wr_err, 0);
    check("mask0_rd2_data", rd2_data, pat);

    // 3. Single-element masked write forwarded to rd1 in the same cycle
    wr_en = 1; wr_addr = 2; wr_mask = 16'h0001; wr_data = ones;
    wr_data[15:0] = 16'hBEEF;
    rd1_en = 1; rd1_addr = 2; rd1_transpose = 0; rd2_en = 0;
    step();
    check("t3_fwd_data", rd1_data, pat_b);
    check("t3_fwd_e00", rd1_data[15:0], 16'hBEEF);
    check("t3_fwd_e33", rd1_data[15*16 +: 16], 15);
    wr_en = 0; rd1_en = 0;
    rd2_en = 1; rd2_addr = 2; rd2_transpose = 1;
    step();
    check("t3_stored_e00", rd2_data[15:0], 16'hBEEF);
    check("t3_stored_t_e10", rd2_data[4*16 +: 16], 1);
    check("t3_rd1_hold", rd1_data, pat_b);
    check("t3_rd1_valid_drop", rd1_valid, 0);
    rd2_en = 0;

    // 4. Out-of-range addresses on the six-entry instance
    s_wr_en = 1; s_wr_addr = 3'd7; s_wr_mask = 16'hFFFF; s_wr_data = ones;
    s_rd2_en = 1; s_rd2_addr = 3'd6;
    step();
    check("t4_wr_err", s_wr_err, 1);
    check("t4_rd2_valid", s_rd2_valid, 1);
    check("t4_rd2_err", s_rd2_err, 1);
    check("t4_rd2_data", s_rd2_data, 0);
    s_wr_en = 0; s_rd2_en = 0;
    step();
    check("t4_wr_err_drop", s_wr_err, 0);
    check("t4_rd2_err_drop", s_rd2_err, 0);
    for (int a = 0; a < 6; a++) begin
      s_rd1_en = 1; s_rd1_addr = 3'(a);
      step();
      check($sformatf("t4_entry_%0d", a), s_rd1_data, 0);
      check($sformatf("t4_entry_err_%0d", a), s_rd1_err, 0);
    end
    s_rd1_en = 0;

    // 5. Clear request drops the coincident write and stalls reads
    clear_req = 1;
    wr_en = 1; wr_addr = 2; wr_mask = 16'hFFFF; wr_data = ones;
    rd1_en = 1; rd1_addr = 2; rd1_transpose = 0;
    step();
    clear_req = 0; wr_en = 0;
    check("t5_busy", busy, 1);
    check("t5_rd1_dropped", rd1_valid, 0);
    check("t5_wr_err", wr_err, 0);
    n = 1;
    saw_valid = 0;
    while (busy && n < 20) begin
      step();
      n++;
      if (rd1_valid) saw_valid = 1;
    end
    check("t5_busy_cycles", n, 9);
    check("t5_no_valid_in_clear", saw_valid, 0);
    step();
    check("t5_post_valid", rd1_valid, 1);
    check("t5_entry2_cleared", rd1_data, 0);
    rd1_en = 0;

    // 6. Reset during clear: async output reset and a full restart
    wr_en = 1; wr_addr = 5; wr_mask = 16'hFFFF; wr_data = pat;
    rd1_en = 1; rd1_addr = 5;
    step();
    wr_en = 0;
    check("t6_preload", rd1_data, pat);
    hold = rd1_data;
    clear_req = 1;
    step();
    clear_req = 0;
    step(); step(); step();
    check("t6_busy_mid", busy, 1);
    check("t6_hold_in_clear", rd1_data, hold);
    #2;
    reset = 0;
    #1;
    check("t6_async_data", rd1_data, 0);
    check("t6_async_valid", rd1_valid, 0);
    check("t6_async_busy", busy, 1);
    rd1_en = 0;
    step();
    reset = 1;
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    check("t6_busy_cycles", n, 8);
    rd1_en = 1; rd1_addr = 5;
    step();
    check("t6_entry5_cleared", rd1_data, 0);
    check("t6_entry5_valid", rd1_valid, 1);
    rd1_en = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
